interleave_example_vop_engine: RTL and testbench

INTERLEAVE_EXAMPLE_VOP_ENGINE -- requirements
Module: interleave_example_vop_engine

---
 rtl/interleave_example_vop_pkg.sv | 48 ++++
 rtl/interleave_example_vop_lane.sv | 31 +++
 rtl/interleave_example_vop_engine.sv | 191 +++++++++++++++++++
 tb/tb_interleave_example_vop_engine.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interleave_example_vop_pkg.sv
// Shared types and the per-lane arithmetic helper for the vector-op stream engine.
package interleave_example_vop_pkg;

  // Widest lane the helper function supports; lanes are zero-extended to this.
  localparam int unsigned LANE_MAX_W = 64;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10,
    ST_DONE  = 2'b11
  } vop_state_e;

  // Lane operation selected by ctrl_mode.
  typedef enum logic [1:0] {
    MODE_ADD     = 2'b00,
    MODE_SUB     = 2'b01,
    MODE_SAT_ADD = 2'b10,
    MODE_PASS    = 2'b11
  } vop_mode_e;

  // One lane operation on zero-extended operands; lw selects the real lane width.
  // Results are masked to lw bits so callers can simply take the low slice.
  function automatic logic [LANE_MAX_W-1:0] vop_lane_op(
    input logic [LANE_MAX_W-1:0] data,
    input logic [LANE_MAX_W-1:0] cval,
    input vop_mode_e             mode,
    input int unsigned           lw
  );
    logic [LANE_MAX_W:0]   lane_max;
    logic [LANE_MAX_W:0]   sum;
    logic [LANE_MAX_W-1:0] mask;
    logic [LANE_MAX_W-1:0] result;
    lane_max = (65'd1 << lw) - 65'd1;
    mask     = lane_max[LANE_MAX_W-1:0];
    sum      = {1'b0, data} + {1'b0, cval};
    case (mode)
      MODE_ADD:     result = sum[LANE_MAX_W-1:0] & mask;
      MODE_SUB:     result = (data - cval) & mask;
      MODE_SAT_ADD: result = (sum > lane_max) ? mask : sum[LANE_MAX_W-1:0];
      MODE_PASS:    result = data & mask;
      default:      result = data & mask;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/interleave_example_vop_lane.sv
// Single-lane combinational operator: applies the selected op to one lane.
module interleave_example_vop_lane
  import interleave_example_vop_pkg::*;
#(
  parameter int C_LANE_WIDTH = 32
) (
  input  logic [C_LANE_WIDTH-1:0] lane_data,
  input  logic [C_LANE_WIDTH-1:0] lane_const,
  input  logic [1:0]              lane_mode,
  output logic [C_LANE_WIDTH-1:0] lane_result
);

  logic [LANE_MAX_W-1:0] wide_result_s;

  // Evaluate the shared lane function at full helper width.
  always_comb begin
    wide_result_s = vop_lane_op(LANE_MAX_W'(lane_data), LANE_MAX_W'(lane_const),
                                vop_mode_e'(lane_mode), C_LANE_WIDTH);
  end

  assign lane_result = wide_result_s[C_LANE_WIDTH-1:0];

  // The helper masks results, so bits above the lane are always zero.
  generate
    if (C_LANE_WIDTH < LANE_MAX_W) begin : g_unused_hi
      logic unused_hi_s;
      assign unused_hi_s = ^wide_result_s[LANE_MAX_W-1:C_LANE_WIDTH];
    end
  endgenerate

endmodule

// File: rtl/interleave_example_vop_engine.sv
// Streaming vector-op engine: per-lane add/sub/sat-add/pass against a latched
// constant, fed through a stall-able valid pipeline, framed by a start/done FSM.
module interleave_example_vop_engine
  import interleave_example_vop_pkg::*;
#(
  parameter int C_DATA_WIDTH      = 512,
  parameter int C_LANE_WIDTH      = 32,
  parameter int C_PIPE_STAGES     = 2,
  parameter int C_XFER_SIZE_WIDTH = 32
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         ap_start,
  output logic                         ap_done,
  output logic                         ap_idle,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  input  logic [C_LANE_WIDTH-1:0]      ctrl_constant,
  input  logic [1:0]                   ctrl_mode,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [C_DATA_WIDTH-1:0]      s_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [C_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                         m_axis_tlast
);

  localparam int XW             = C_XFER_SIZE_WIDTH;
  localparam int NUM_LANES      = C_DATA_WIDTH / C_LANE_WIDTH;
  localparam int BYTES_PER_BEAT = C_DATA_WIDTH / 8;
  localparam logic [XW-1:0] BPB_W   = XW'(BYTES_PER_BEAT);
  localparam logic [XW-1:0] CNT_ONE = XW'(1);
  localparam logic [XW-1:0] CNT_ZERO = {XW{1'b0}};

  // Control state
  vop_state_e            state_r;
  vop_state_e            state_next_s;
  vop_mode_e             mode_r;
  logic [C_LANE_WIDTH-1:0] const_r;
  logic [XW-1:0]         target_r;
  logic [XW-1:0]         in_cnt_r;
  logic [XW-1:0]         out_cnt_r;
  logic                  ap_done_r;
  logic                  ap_idle_r;

  // Beat-count computation
  logic [XW-1:0]         beat_quot_s;
  logic [XW-1:0]         beat_rem_s;
  logic [XW-1:0]         beat_target_s;

  // Handshake / pipeline control
  logic                  start_s;
  logic                  advance_s;
  logic                  in_hs_s;
  logic                  in_last_s;
  logic                  out_hs_s;
  logic                  out_last_s;

  // Pipeline storage; tlast rides along as a sideband bit
  logic [C_DATA_WIDTH-1:0] lane_res_s;
  logic [C_DATA_WIDTH-1:0] pipe_data_r [C_PIPE_STAGES];
  logic [C_PIPE_STAGES-1:0] pipe_valid_r;
  logic [C_PIPE_STAGES-1:0] pipe_last_r;

  // Beats = ceil(bytes / bytes-per-beat), done without widening the input.
  assign beat_quot_s   = ctrl_xfer_size_in_bytes / BPB_W;
  assign beat_rem_s    = ctrl_xfer_size_in_bytes % BPB_W;
  assign beat_target_s = beat_quot_s + {{(XW-1){1'b0}}, (beat_rem_s != CNT_ZERO)};

  assign start_s    = (state_r == ST_IDLE) && ap_start;
  // Whole pipeline moves together when the output slot can drain.
  assign advance_s  = !pipe_valid_r[C_PIPE_STAGES-1] || m_axis_tready;
  assign s_axis_tready = (state_r == ST_RUN) && advance_s;
  assign in_hs_s    = s_axis_tvalid && s_axis_tready;
  assign in_last_s  = in_hs_s && (in_cnt_r == (target_r - CNT_ONE));
  assign out_hs_s   = m_axis_tvalid && m_axis_tready;
  assign out_last_s = out_hs_s && (out_cnt_r == (target_r - CNT_ONE));

  assign m_axis_tvalid = pipe_valid_r[C_PIPE_STAGES-1];
  assign m_axis_tdata  = pipe_data_r[C_PIPE_STAGES-1];
  assign m_axis_tlast  = pipe_valid_r[C_PIPE_STAGES-1] & pipe_last_r[C_PIPE_STAGES-1];
  assign ap_done       = ap_done_r;
  assign ap_idle       = ap_idle_r;

  // One operator per lane on the incoming beat; results feed stage 0.
  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      interleave_example_vop_lane #(
        .C_LANE_WIDTH (C_LANE_WIDTH)
      ) u_lane (
        .lane_data   (s_axis_tdata[i*C_LANE_WIDTH +: C_LANE_WIDTH]),
        .lane_const  (const_r),
        .lane_mode   (mode_r),
        .lane_result (lane_res_s[i*C_LANE_WIDTH +: C_LANE_WIDTH])
      );
    end
  endgenerate

  // Next-state logic for the start/run/flush/done sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ap_start) begin
          if (beat_target_s == CNT_ZERO) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_RUN;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (in_last_s) begin
          state_next_s = ST_FLUSH;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (out_last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_FLUSH;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register, status outputs, transfer parameters and beat counters.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r   <= ST_IDLE;
      ap_done_r <= 1'b0;
      ap_idle_r <= 1'b1;
      mode_r    <= MODE_ADD;
      const_r   <= {C_LANE_WIDTH{1'b0}};
      target_r  <= CNT_ZERO;
      in_cnt_r  <= CNT_ZERO;
      out_cnt_r <= CNT_ZERO;
    end else begin
      state_r   <= state_next_s;
      ap_done_r <= (state_next_s == ST_DONE);
      ap_idle_r <= (state_next_s == ST_IDLE);
      if (start_s) begin
        // Parameters are captured only here, so mid-transfer changes are ignored.
        mode_r    <= vop_mode_e'(ctrl_mode);
        const_r   <= ctrl_constant;
        target_r  <= beat_target_s;
        in_cnt_r  <= CNT_ZERO;
        out_cnt_r <= CNT_ZERO;
      end else begin
        if (in_hs_s) begin
          in_cnt_r <= in_cnt_r + CNT_ONE;
        end
        if (out_hs_s) begin
          out_cnt_r <= out_cnt_r + CNT_ONE;
        end
      end
    end
  end

  // Pipeline valid and tlast sideband; reset empties all stages.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pipe_valid_r <= {C_PIPE_STAGES{1'b0}};
      pipe_last_r  <= {C_PIPE_STAGES{1'b0}};
    end else if (advance_s) begin
      pipe_valid_r[0] <= in_hs_s;
      pipe_last_r[0]  <= in_last_s;
      for (int k = 1; k < C_PIPE_STAGES; k++) begin
        pipe_valid_r[k] <= pipe_valid_r[k-1];
        pipe_last_r[k]  <= pipe_last_r[k-1];
      end
    end
  end

  // Pipeline data; qualified by the valid bits, so no reset is needed.
  always_ff @(posedge aclk) begin
    if (advance_s) begin
      pipe_data_r[0] <= lane_res_s;
      for (int k = 1; k < C_PIPE_STAGES; k++) begin
        pipe_data_r[k] <= pipe_data_r[k-1];
      end
    end
  end

endmodule

// File: tb/tb_interleave_example_vop_engine.sv
// Directed bench for the vector-op engine: lane-op vector table plus hand-written
// sequences for latency, beat rounding, zero-length, back-pressure and reset abort.
module tb_interleave_example_vop_engine;

  localparam int DW = 512;
  localparam int LW = 8;
  localparam int PS = 2;
  localparam int XW = 32;
  localparam int NL = DW / LW;

  logic          aclk;
  logic          aresetn;
  logic          ap_start;
  logic          ap_done;
  logic          ap_idle;
  logic [XW-1:0] ctrl_xfer_size_in_bytes;
  logic [LW-1:0] ctrl_constant;
  logic [1:0]    ctrl_mode;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;

  interleave_example_vop_engine #(
    .C_DATA_WIDTH      (DW),
    .C_LANE_WIDTH      (LW),
    .C_PIPE_STAGES     (PS),
    .C_XFER_SIZE_WIDTH (XW)
  ) dut (
    .aclk                    (aclk),
    .aresetn                 (aresetn),
    .ap_start                (ap_start),
    .ap_done                 (ap_done),
    .ap_idle                 (ap_idle),
    .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
    .ctrl_constant           (ctrl_constant),
    .ctrl_mode               (ctrl_mode),
    .s_axis_tvalid           (s_axis_tvalid),
    .s_axis_tready           (s_axis_tready),
    .s_axis_tdata            (s_axis_tdata),
    .m_axis_tvalid           (m_axis_tvalid),
    .m_axis_tready           (m_axis_tready),
    .m_axis_tdata            (m_axis_tdata),
    .m_axis_tlast            (m_axis_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Monitor-side records
  int            in_cyc_q[$];
  int            out_cyc_q[$];
  logic [DW-1:0] out_data_q[$];
  logic          out_last_q[$];
  int            done_cyc_q[$];
  logic          stall_pend = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  int            stall_seen = 0;
  int            stall_errs = 0;

  typedef struct {
    logic [1:0]    mode;
    logic [LW-1:0] cval;
    logic [LW-1:0] lane_val;
    logic [LW-1:0] lane0_val;
    logic [LW-1:0] exp_val;
    logic [LW-1:0] exp0_val;
  } vec_t;
  vec_t vecs[8];

  always @(posedge aclk) cyc <= cyc + 1;

  // Records handshakes and done pulses, and checks output stability while stalled.
  always @(negedge aclk) begin
    if (!aresetn) begin
      stall_pend <= 1'b0;
    end else begin
      if (stall_pend) begin
        stall_seen <= stall_seen + 1;
        if (!m_axis_tvalid || (m_axis_tdata !== prev_data) || (m_axis_tlast !== prev_last))
          stall_errs <= stall_errs + 1;
      end
      stall_pend <= m_axis_tvalid && !m_axis_tready;
      prev_data  <= m_axis_tdata;
      prev_last  <= m_axis_tlast;
      if (s_axis_tvalid && s_axis_tready) in_cyc_q.push_back(cyc);
      if (m_axis_tvalid && m_axis_tready) begin
        out_cyc_q.push_back(cyc);
        out_data_q.push_back(m_axis_tdata);
        out_last_q.push_back(m_axis_tlast);
      end
      if (ap_done) done_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [LW-1:0] v, input logic [LW-1:0] v0);
    logic [DW-1:0] d;
    for (int i = 0; i < NL; i++) d[i*LW +: LW] = v;
    d[LW-1:0] = v0;
    return d;
  endfunction

  task automatic clear_q();
    in_cyc_q.delete(); out_cyc_q.delete(); out_data_q.delete();
    out_last_q.delete(); done_cyc_q.delete();
  endtask

  task automatic start_xfer(input logic [XW-1:0] bytes, input logic [1:0] mode,
                            input logic [LW-1:0] cval);
    @(posedge aclk); #1;
    ap_start = 1'b1; ctrl_xfer_size_in_bytes = bytes; ctrl_mode = mode; ctrl_constant = cval;
    @(posedge aclk); #1;
    ap_start = 1'b0;
    // Scramble control inputs: the engine must use the latched values.
    ctrl_xfer_size_in_bytes = 32'd4096; ctrl_mode = ~mode; ctrl_constant = ~cval;
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    int w;
    w = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    @(negedge aclk);
    while (!s_axis_tready && w < 500) begin
      @(negedge aclk);
      w++;
    end
    if (!s_axis_tready) begin
      checks++; failures++;
      $display("FAIL in_timeout: got tready=0 expected tready=1 within 500 cycles");
    end
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int w;
    w = 0;
    while (done_cyc_q.size() == 0 && w < 2000) begin
      @(negedge aclk); #1;
      w++;
    end
    chk({name, "_done_seen"}, DW'(done_cyc_q.size() != 0), DW'(1));
    repeat (3) @(negedge aclk);
    @(posedge aclk); #1;
    chk({name, "_done_count"}, DW'(done_cyc_q.size()), DW'(1));
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    int            nlast;
    int            acc;
    logic          rstop;

    vecs[0] = '{2'b00, 8'h05, 8'h10, 8'hFF, 8'h15, 8'h04};
    vecs[1] = '{2'b01, 8'h01, 8'h00, 8'h05, 8'hFF, 8'h04};
    vecs[2] = '{2'b10, 8'h10, 8'hF8, 8'h20, 8'hFF, 8'h30};
    vecs[3] = '{2'b11, 8'hAA, 8'h3C, 8'hFF, 8'h3C, 8'hFF};
    vecs[4] = '{2'b00, 8'h10, 8'h01, 8'hF8, 8'h11, 8'h08};
    vecs[5] = '{2'b10, 8'hFF, 8'h00, 8'h01, 8'hFF, 8'hFF};
    vecs[6] = '{2'b01, 8'h80, 8'h7F, 8'h80, 8'hFF, 8'h00};
    vecs[7] = '{2'b10, 8'h01, 8'hFE, 8'hFF, 8'hFF, 8'hFF};

    aresetn = 1'b0; ap_start = 1'b0; ctrl_xfer_size_in_bytes = 32'd0;
    ctrl_constant = 8'h00; ctrl_mode = 2'b00; s_axis_tvalid = 1'b0;
    s_axis_tdata = {DW{1'b0}}; m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_ap_idle", DW'(ap_idle), DW'(1));
    chk("rst_ap_done", DW'(ap_done), DW'(0));
    chk("rst_s_tready", DW'(s_axis_tready), DW'(0));
    chk("rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("rst_m_tlast", DW'(m_axis_tlast), DW'(0));
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // Four-beat add with 2-cycle latency and full throughput
    clear_q();
    start_xfer(32'd256, 2'b00, 8'h05);
    for (int k = 0; k < 4; k++) send_beat(fill(8'h10, 8'h10));
    wait_done("a");
    chk("a_out_count", DW'(out_data_q.size()), DW'(4));
    if (out_data_q.size() == 4 && in_cyc_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("a_data%0d", k), out_data_q[k], fill(8'h15, 8'h15));
        chk($sformatf("a_last%0d", k), DW'(out_last_q[k]), DW'(k == 3));
        chk($sformatf("a_latency%0d", k), DW'(out_cyc_q[k] - in_cyc_q[k]), DW'(2));
      end
      chk("a_throughput", DW'(in_cyc_q[3] - in_cyc_q[0]), DW'(3));
      chk("a_done_timing", DW'(done_cyc_q[0] - out_cyc_q[3]), DW'(1));
    end
    chk("a_idle_after", DW'(ap_idle), DW'(1));

    // Lane-operation vector table, one-beat transfers
    for (int v = 0; v < 8; v++) begin
      clear_q();
      start_xfer(32'd64, vecs[v].mode, vecs[v].cval);
      send_beat(fill(vecs[v].lane_val, vecs[v].lane0_val));
      wait_done($sformatf("v%0d", v));
      chk($sformatf("v%0d_count", v), DW'(out_data_q.size()), DW'(1));
      if (out_data_q.size() == 1) begin
        chk($sformatf("v%0d_data", v), out_data_q[0], fill(vecs[v].exp_val, vecs[v].exp0_val));
        chk($sformatf("v%0d_last", v), DW'(out_last_q[0]), DW'(1));
      end
    end

    // 100 bytes rounds up to 2 beats; a third beat stalls; mid-run ap_start ignored
    clear_q();
    start_xfer(32'd100, 2'b11, 8'h00);
    send_beat(fill(8'h41, 8'h41));
    ap_start = 1'b1; ctrl_xfer_size_in_bytes = 32'd4096;
    send_beat(fill(8'h42, 8'h42));
    ap_start = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = fill(8'h43, 8'h43);
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      if (s_axis_tready) acc++;
    end
    s_axis_tvalid = 1'b0;
    chk("b_third_tready", DW'(acc), DW'(0));
    wait_done("b");
    chk("b_in_count", DW'(in_cyc_q.size()), DW'(2));
    chk("b_out_count", DW'(out_data_q.size()), DW'(2));
    if (out_data_q.size() == 2) begin
      chk("b_data1", out_data_q[1], fill(8'h42, 8'h42));
      chk("b_last0", DW'(out_last_q[0]), DW'(0));
      chk("b_last1", DW'(out_last_q[1]), DW'(1));
    end

    // Zero-byte transfer goes straight to done
    clear_q();
    @(posedge aclk); #1;
    ap_start = 1'b1; ctrl_xfer_size_in_bytes = 32'd0;
    @(negedge aclk);
    chk("z_done_pre", DW'(ap_done), DW'(0));
    @(posedge aclk); #1;
    ap_start = 1'b0;
    @(negedge aclk);
    chk("z_done_pulse", DW'(ap_done), DW'(1));
    chk("z_idle_in_done", DW'(ap_idle), DW'(0));
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      if (s_axis_tready || m_axis_tvalid || ap_done) acc++;
    end
    chk("z_quiet_after", DW'(acc), DW'(0));
    chk("z_idle_after", DW'(ap_idle), DW'(1));
    chk("z_done_count", DW'(done_cyc_q.size()), DW'(1));

    // 64 beats under random back-pressure
    clear_q();
    rstop = 1'b0;
    start_xfer(32'd4096, 2'b00, 8'h03);
    fork
      begin
        for (int k = 0; k < 64; k++) begin
          for (int i = 0; i < NL; i++) d[i*LW +: LW] = 8'(k + i);
          send_beat(d);
        end
        wait_done("r");
        rstop = 1'b1;
      end
      begin
        for (int g = 0; g < 20000 && !rstop; g++) begin
          @(posedge aclk); #1;
          m_axis_tready = 1'($urandom_range(0, 1));
        end
        m_axis_tready = 1'b1;
      end
    join
    chk("r_out_count", DW'(out_data_q.size()), DW'(64));
    nlast = 0;
    acc = 0;
    if (out_data_q.size() == 64) begin
      for (int k = 0; k < 64; k++) begin
        for (int i = 0; i < NL; i++) e[i*LW +: LW] = 8'(k + i + 3);
        if (out_data_q[k] !== e) acc++;
        if (out_last_q[k]) nlast++;
      end
      chk("r_data_mismatches", DW'(acc), DW'(0));
      chk("r_last_count", DW'(nlast), DW'(1));
      chk("r_last_pos", DW'(out_last_q[63]), DW'(1));
    end
    chk("r_stalls_seen", DW'(stall_seen != 0), DW'(1));
    chk("r_stall_stability", DW'(stall_errs), DW'(0));

    // Reset after 3 of 8 beats aborts; a new transfer then completes
    clear_q();
    m_axis_tready = 1'b1;
    start_xfer(32'd512, 2'b00, 8'h01);
    for (int k = 0; k < 3; k++) send_beat(fill(8'h20, 8'h20));
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    clear_q();
    @(negedge aclk);
    chk("x_idle", DW'(ap_idle), DW'(1));
    chk("x_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("x_s_tready", DW'(s_axis_tready), DW'(0));
    repeat (10) @(negedge aclk);
    chk("x_no_done", DW'(done_cyc_q.size()), DW'(0));
    chk("x_no_out", DW'(out_data_q.size()), DW'(0));
    start_xfer(32'd64, 2'b01, 8'h02);
    send_beat(fill(8'h01, 8'h07));
    wait_done("x2");
    chk("x2_count", DW'(out_data_q.size()), DW'(1));
    if (out_data_q.size() == 1) begin
      chk("x2_data", out_data_q[0], fill(8'hFF, 8'h05));
      chk("x2_last", DW'(out_last_q[0]), DW'(1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
